spi_byte_master: RTL
====================

Name: spi_byte_master

Overview:
- Byte-level SPI master serving the SPI command path of the command processor. It drives the ADC, PLL and clock-chip configuration SPI buses.
- It accepts one byte per handshake on the spitx/spitxdv/spitxready interface and shifts it out MSB-first on spimosi while capturing spimiso.
- It returns the received byte on spirx with a one-cycle spirxdv strobe.
- Chip select is not handled here: spics and the MISO mux select stay in the command processor, which holds CS low across multi-byte transfers.

Parameters:
- CLKS_PER_HALF_BIT, 4, clk cycles per SCLK half-period; legal range 2..255.
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0: sample on leading edge, shift on trailing edge; 1: shift on leading edge, sample on trailing edge.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- spitx  input  8  byte to transmit; sampled only on accept.
- spitxdv  input  1  transmit request; accepted when spitxready=1.
- spitxready  output  1  high when idle and able to accept a byte.
- spirx  output  8  last received byte; holds until the next byte completes.
- spirxdv  output  1  one-cycle strobe: spirx updated.
- spisclk  output  1  SPI clock.
- spimosi  output  1  SPI data out.
- spimiso  input  1  SPI data in, already muxed externally.

Behaviour:
- Reset (rst=1 at a clk edge, including mid-byte): spisclk=CPOL, spimosi=0, spitxready=1, spirxdv=0, spirx=8'h00. Counters and shift registers clear, the state goes to IDLE, and the partial byte is discarded with no strobe.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - spitxready=1.
  - If spitxdv=1 (accept at cycle 0): latch spitx into tx_shift, clear the edge counter (5 bits) and half-bit counter (8 bits), go to SHIFT, spitxready=0 from cycle 1.
  - If CPHA=0: spimosi=spitx[7] from cycle 1.
  - spitxdv=0 in IDLE: no action. spitxdv while spitxready=0: ignored, byte not queued.
- SHIFT:
  - The half-bit counter counts 0..CLKS_PER_HALF_BIT-1. On wrap, spisclk toggles and the edge counter increments.
  - Exactly 16 edges; edge k occurs at cycle k*CLKS_PER_HALF_BIT. Odd edges are leading, even edges are trailing.
  - Sampling edge: spimiso is shifted into rx_shift LSB at the same clk edge that toggles spisclk.
  - Shifting edge: spimosi takes the next lower tx bit.
  - CPHA=1: bit 7 is driven at edge 1.
  - CPHA=0: no shift after edge 16.
  - After edge 16, spisclk=CPOL; go to DONE.
- DONE (exactly one cycle, cycle 16*CLKS_PER_HALF_BIT+1):
  - spirx<=rx_shift, spirxdv=1, spitxready=1.
  - If spitxdv=1 in this cycle, the next byte is accepted: back-to-back transfer, SCLK stays at CPOL for at least one clk cycle. Otherwise go to IDLE.
- spimosi holds its last driven bit after a transfer and updates only at accept or on shifting edges.
- spirxdv is never asserted for more than one consecutive cycle. A reset asserted in the DONE cycle suppresses the strobe.
- Accept-to-strobe latency: exactly 16*CLKS_PER_HALF_BIT+1 cycles. Throughput: one byte per 16*CLKS_PER_HALF_BIT+1 cycles.
- spisclk and spimosi are registered outputs; no combinational path from inputs to outputs.

Test Plan:
- CLKS_PER_HALF_BIT=2, CPOL=0, CPHA=0, spimiso tied to spimosi; send 8'hA5 -> spimosi shows 1,0,1,0,0,1,0,1 on rising edges; 16 spisclk edges at cycles 2,4,..,32; spirxdv single pulse at cycle 33; spirx=8'hA5; spitxready low in cycles 1..32.
- Mode 3 (CPOL=1, CPHA=1); slave model returns 8'h3C while 8'h80 is sent -> spisclk idles high, MOSI changes on falling edges, spirx=8'h3C.
- Three-byte write 8'h00,8'h15,8'h7F with spitxdv asserted in each DONE cycle -> bytes transmitted in order; three spirxdv pulses 33 cycles apart (H=2); no lost or duplicated byte.
- Pulse spitxdv with spitx=8'hFF at cycle 10 of a transfer of 8'h12 -> ignored; only 8'h12 seen on bus; one spirxdv.
- Assert rst at cycle 17 of a transfer -> next cycle: spisclk=CPOL, spitxready=1, spirx=8'h00, no spirxdv; a subsequent 8'h5A transfers correctly.
- CLKS_PER_HALF_BIT=255: send 8'hC3 -> half-periods of exactly 255 cycles; spirxdv at cycle 4081.

Source files
------------

// File: rtl/spi_byte_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_byte_master
//  Description : Byte-level SPI master for the command processor's SPI
//                command path (ADC, PLL and clock-chip configuration buses).
//                Accepts one byte per spitxdv/spitxready handshake, shifts it
//                out MSB-first on spimosi while capturing spimiso, and returns
//                the received byte on spirx with a one-cycle spirxdv strobe.
//                Chip select and the MISO mux select live in the command
//                processor; this block only generates SCLK and data.
//
//  Parameters  : CLKS_PER_HALF_BIT  clk cycles per SCLK half-period (2..255)
//                CPOL               SCLK idle level
//                CPHA               0: sample leading / shift trailing edge
//                                   1: shift leading / sample trailing edge
//
//  Ports       : clk         in   system clock, rising edge
//                rst         in   synchronous active-high reset
//                spitx       in   [7:0] byte to send, sampled on accept
//                spitxdv     in   transmit request
//                spitxready  out  high when a byte can be accepted
//                spirx       out  [7:0] last received byte
//                spirxdv     out  one-cycle strobe, spirx updated
//                spisclk     out  SPI clock (registered)
//                spimosi     out  SPI data out (registered)
//                spimiso     in   SPI data in, externally muxed
//
//  Revision    : 1.0  initial release
// ============================================================================
module spi_byte_master #(
   parameter int unsigned CLKS_PER_HALF_BIT = 4,
   parameter bit          CPOL              = 1'b0,
   parameter bit          CPHA              = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] spitx,
   input  logic       spitxdv,
   output logic       spitxready,
   output logic [7:0] spirx,
   output logic       spirxdv,
   output logic       spisclk,
   output logic       spimosi,
   input  logic       spimiso
);

   // Terminal value of the half-bit counter; the SCLK edge fires on wrap.
   localparam logic [7:0] c_half_last = 8'(CLKS_PER_HALF_BIT - 1);
   // A byte is always exactly 16 SCLK edges; the edge counter holds the
   // number of edges already produced, so 15 means "the next edge is last".
   localparam logic [4:0] c_last_edge_cnt = 5'd15;
   localparam logic [4:0] c_final_edge    = 5'd16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [7:0]  r_half_cnt;
   logic [4:0]  r_edge_cnt;
   logic [7:0]  r_tx_shift;
   logic [7:0]  r_rx_shift;
   logic [7:0]  r_spirx;
   logic        r_sclk;
   logic        r_mosi;

   logic        w_accept;
   logic        w_ready;
   logic        w_rxdv;
   logic        w_half_wrap;
   logic [4:0]  w_edge_num;
   logic        w_leading;
   logic        w_sample_edge;
   logic        w_shift_edge;
   logic        w_last_edge;
   logic [7:0]  w_rx_next;

   // ------------------------------------------------------------------------
   // Edge classification. w_edge_num is the 1-based index of the edge that
   // fires when the half-bit counter wraps this cycle; odd edges leave the
   // idle level (leading), even edges return to it (trailing).
   // ------------------------------------------------------------------------
   assign w_half_wrap = (r_half_cnt == c_half_last);
   assign w_edge_num  = r_edge_cnt + 5'd1;
   assign w_leading   = w_edge_num[0];
   assign w_last_edge = (r_edge_cnt == c_last_edge_cnt);
   assign w_rx_next   = {r_rx_shift[6:0], spimiso};

   // CPHA=0 already presented bit 7 at accept, so its trailing edges move to
   // bits 6..0 and the 16th (final trailing) edge must not shift again.
   // CPHA=1 presents each bit on a leading edge, starting with bit 7.
   always_comb begin
      w_sample_edge = 1'b0;
      w_shift_edge  = 1'b0;
      if (CPHA == 1'b0) begin
         w_sample_edge = w_leading;
         w_shift_edge  = !w_leading && (w_edge_num != c_final_edge);
      end else begin
         w_sample_edge = !w_leading;
         w_shift_edge  = w_leading;
      end
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and handshake decode. DONE lasts exactly one cycle and may
   // accept the following byte directly, which gives back-to-back transfers
   // with SCLK parked at CPOL for that one DONE cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_ready      = 1'b0;
      w_rxdv       = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready = 1'b1;
            if (spitxdv) begin
               w_accept     = 1'b1;
               w_next_state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_half_wrap && w_last_edge) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_ready = 1'b1;
            w_rxdv  = 1'b1;
            if (spitxdv) begin
               w_accept     = 1'b1;
               w_next_state = ST_SHIFT;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: counters, shift registers and the registered SPI outputs.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_half_cnt <= 8'd0;
         r_edge_cnt <= 5'd0;
         r_tx_shift <= 8'd0;
         r_rx_shift <= 8'd0;
         r_spirx    <= 8'd0;
         r_sclk     <= CPOL;
         r_mosi     <= 1'b0;
      end else if (w_accept) begin
         r_half_cnt <= 8'd0;
         r_edge_cnt <= 5'd0;
         r_rx_shift <= 8'd0;
         r_sclk     <= CPOL;
         if (CPHA == 1'b0) begin
            // Bit 7 goes out immediately; the register keeps bits 6..0
            // MSB-aligned so every shifting edge takes r_tx_shift[7].
            r_mosi     <= spitx[7];
            r_tx_shift <= {spitx[6:0], 1'b0};
         end else begin
            r_tx_shift <= spitx;
         end
      end else if (r_state == ST_SHIFT) begin
         if (w_half_wrap) begin
            r_half_cnt <= 8'd0;
            r_edge_cnt <= w_edge_num;
            r_sclk     <= ~r_sclk;
            if (w_sample_edge) begin
               r_rx_shift <= w_rx_next;
            end
            if (w_shift_edge) begin
               r_mosi     <= r_tx_shift[7];
               r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
            if (w_last_edge) begin
               r_sclk <= CPOL;
               // With CPHA=1 the final edge is also the last sample, so
               // the completed byte must include this cycle's spimiso.
               if (w_sample_edge) begin
                  r_spirx <= w_rx_next;
               end else begin
                  r_spirx <= r_rx_shift;
               end
            end
         end else begin
            r_half_cnt <= r_half_cnt + 8'd1;
         end
      end
   end

   assign spitxready = w_ready;
   // Gated by rst so a reset arriving in the DONE cycle cancels the strobe.
   assign spirxdv    = w_rxdv && !rst;
   assign spirx      = r_spirx;
   assign spisclk    = r_sclk;
   assign spimosi    = r_mosi;

endmodule
`default_nettype wire
